operand_issue: RTL and testbench
================================

Name: operand_issue

Overview:
- Issue stage directly upstream of the execution stage: holds the architectural register file and reads rs1/rs2 operands.
- Tracks pending destination writes with a scoreboard and stalls on hazards.
- Presents one registered operation (func, rs1/rs2 data, raw 6-bit imm, rd) to the execution stage per valid/ready handshake.
- Accepts writeback of execution results into the register file.

Parameters:
- NUM_REGS, 16, number of architectural registers.
- ADDR_W, $clog2(NUM_REGS), register address width.
- DW, DATA_WIDTH (simple_processor_pkg), operand and register data width.

Ports:
- clk_i  in  1  clock.
- arst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  decoded op valid.
- in_ready_o  out  1  op accepted this cycle when in_valid_i=1.
- in_func_i  in  func_t  operation.
- in_rs1_addr_i  in  ADDR_W  source 1 index.
- in_rs2_addr_i  in  ADDR_W  source 2 index.
- in_rd_addr_i  in  ADDR_W  destination index.
- in_imm_i  in  6  raw immediate.
- out_valid_o  out  1  issued op valid to execution.
- out_ready_i  in  1  execution consumes op.
- func_o  out  func_t  issued operation.
- rs1_data_o  out  DW  operand 1.
- rs2_data_o  out  DW  operand 2.
- imm_o  out  6  immediate, passed unextended; sign extension is done in execution.
- rd_addr_o  out  ADDR_W  destination.
- wb_valid_i  in  1  writeback strobe.
- wb_addr_i  in  ADDR_W  writeback register.
- wb_data_i  in  DW  writeback data.
- pending_o  out  NUM_REGS  scoreboard bits, debug/visibility.

Behaviour:
- Reset (arst_ni=0, asynchronous): all registers=0, scoreboard=0, out_valid_o=0, func_o=AND, rs1_data_o=rs2_data_o=0, imm_o=0, rd_addr_o=0. Any in-flight op is discarded.
- uses_rs2 = func not in {ADDI, SLLI, SLRI, NOT}.
- eff_pending[r] = pending[r] AND NOT(wb_valid_i AND wb_addr_i==r). A same-cycle writeback resolves the hazard.
- hazard = eff_pending[rs1] OR (uses_rs2 AND eff_pending[rs2]) OR eff_pending[rd] (WAW).
- in_ready_o = (!out_valid_o OR out_ready_i) AND !hazard. Combinational on in_*_addr/func and wb_*; never depends on in_valid_i.
- Accept (in_valid_i AND in_ready_o) at edge N:
  - outputs load at N+1, out_valid_o=1.
  - throughput 1 op/cycle with no hazard.
- Operand read bypass: if wb_valid_i AND wb_addr_i==rsX, the captured data is wb_data_i; otherwise the register file value.
- Output hold: while out_valid_o=1 AND out_ready_i=0, all out_* stay stable.
- Drain: out_ready_i=1 with no accept clears out_valid_o next cycle.
- Register file write: wb_valid_i writes wb_data_i to wb_addr_i at the clock edge, whether or not that register is pending.
- Scoreboard:
  - accept sets pending[rd]; wb_valid_i clears pending[wb_addr_i].
  - same register, same cycle: set wins.
  - writeback to a non-pending register leaves its bit 0.
- Out-of-range addresses (>= NUM_REGS) read 0 and ignore writes.

Optional Feature:
- Macro: OPERAND_ISSUE_ZERO_REG_EN.
- Defined: r0 is hardwired zero.
  - reads of r0 return 0, including under bypass.
  - writebacks to r0 are dropped.
  - pending[0] is never set; r0 never causes a hazard.
- Undefined: r0 is an ordinary register.

Test Plan:
- Reset: hold arst_ni=0 for 100ns mid-traffic -> out_valid_o=0, pending_o=0, in_ready_o=1; subsequent reads of r1..r15 return 0.
- Basic issue: wb r1=A5A5A5A5, r2=5A5A5A5A; then issue AND rs1=1 rs2=2 rd=3 -> next cycle out_valid_o=1, rs1_data_o=A5A5A5A5, rs2_data_o=5A5A5A5A, rd_addr_o=3, pending_o[3]=1.
- RAW stall plus bypass:
  - issue ADDI rd=4 rs1=1 imm=03, then present ADD rs1=4 rs2=1 -> in_ready_o=0 until wb_valid_i with r4=00000004.
  - in that cycle in_ready_o=1; next cycle rs1_data_o=00000004, pending_o[4]=1 (set wins).
- Backpressure: out_ready_i=0 for 3 cycles with an op issued -> out_* unchanged, in_ready_o=0; raise out_ready_i -> the queued op appears next cycle.
- Immediate ignores rs2: pending_o[5]=1; issue SLLI rs1=1 rs2-field=5 imm=02 -> accepted immediately. The same op as SLL -> stalled.
- Zero register: wb r0=FFFFFFFF, issue OR rs1=0 rs2=0 -> rs1_data_o=0 with OPERAND_ISSUE_ZERO_REG_EN; FFFFFFFF without it.

Source files
------------

// File: rtl/operand_issue.sv
// Issue stage: register file, pending-write scoreboard with hazard stall, and a
// registered operation slot toward execution. OPERAND_ISSUE_ZERO_REG_EN makes r0 a hardwired zero.
package simple_processor_pkg;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        AND  = 4'd0,
        OR   = 4'd1,
        XOR  = 4'd2,
        NOT  = 4'd3,
        ADD  = 4'd4,
        SUB  = 4'd5,
        SLL  = 4'd6,
        SLR  = 4'd7,
        ADDI = 4'd8,
        SLLI = 4'd9,
        SLRI = 4'd10
    } func_t;
endpackage

module operand_issue
    import simple_processor_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned DW       = DATA_WIDTH
) (
    input  logic                clk_i,
    input  logic                arst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  func_t               in_func_i,
    input  logic [ADDR_W-1:0]   in_rs1_addr_i,
    input  logic [ADDR_W-1:0]   in_rs2_addr_i,
    input  logic [ADDR_W-1:0]   in_rd_addr_i,
    input  logic [5:0]          in_imm_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output func_t               func_o,
    output logic [DW-1:0]       rs1_data_o,
    output logic [DW-1:0]       rs2_data_o,
    output logic [5:0]          imm_o,
    output logic [ADDR_W-1:0]   rd_addr_o,
    input  logic                wb_valid_i,
    input  logic [ADDR_W-1:0]   wb_addr_i,
    input  logic [DW-1:0]       wb_data_i,
    output logic [NUM_REGS-1:0] pending_o
);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W+1)'(NUM_REGS);
    endfunction

    // Registers that hold state; everything else reads as zero and drops writes.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
`ifdef OPERAND_ISSUE_ZERO_REG_EN
        return in_range(a) && (a != '0);
`else
        return in_range(a);
`endif
    endfunction

    logic [DW-1:0]       regs [NUM_REGS];
    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] eff_pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [DW-1:0]       rs1_val;
    logic [DW-1:0]       rs2_val;
    logic                uses_rs2;
    logic                hazard;
    logic                accept;

    assign uses_rs2 = !(in_func_i inside {ADDI, SLLI, SLRI, NOT});

    // A writeback landing this cycle clears its hazard immediately.
    always_comb begin
        wb_hit = '0;
        if (wb_valid_i && in_range(wb_addr_i)) begin
            wb_hit[wb_addr_i] = 1'b1;
        end
        eff_pending = pending_o & ~wb_hit;
    end

    always_comb begin
        hazard = 1'b0;
        if (in_range(in_rs1_addr_i) && eff_pending[in_rs1_addr_i]) begin
            hazard = 1'b1;
        end
        if (uses_rs2 && in_range(in_rs2_addr_i) && eff_pending[in_rs2_addr_i]) begin
            hazard = 1'b1;
        end
        if (in_range(in_rd_addr_i) && eff_pending[in_rd_addr_i]) begin
            hazard = 1'b1;
        end
    end

    assign in_ready_o = (!out_valid_o || out_ready_i) && !hazard;
    assign accept     = in_valid_i && in_ready_o;

    // Operand read with writeback bypass.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (writable(in_rs1_addr_i)) begin
            rs1_val = (wb_valid_i && wb_addr_i == in_rs1_addr_i) ? wb_data_i : regs[in_rs1_addr_i];
        end
        if (writable(in_rs2_addr_i)) begin
            rs2_val = (wb_valid_i && wb_addr_i == in_rs2_addr_i) ? wb_data_i : regs[in_rs2_addr_i];
        end
    end

    // Issue sets the destination bit after writeback clears, so set wins.
    always_comb begin
        pending_nxt = pending_o & ~wb_hit;
        if (accept && writable(in_rd_addr_i)) begin
            pending_nxt[in_rd_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid_i && writable(wb_addr_i)) begin
            regs[wb_addr_i] <= wb_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            pending_o <= '0;
        end else begin
            pending_o <= pending_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            out_valid_o <= 1'b0;
            func_o      <= AND;
            rs1_data_o  <= '0;
            rs2_data_o  <= '0;
            imm_o       <= '0;
            rd_addr_o   <= '0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            func_o      <= in_func_i;
            rs1_data_o  <= rs1_val;
            rs2_data_o  <= rs2_val;
            imm_o       <= in_imm_i;
            rd_addr_o   <= in_rd_addr_i;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_issue.sv
// Randomized bench for operand_issue against an array/scoreboard reference model,
// preceded by directed scenarios for stall, bypass, backpressure and r0 handling.
module tb_operand_issue;
    import simple_processor_pkg::*;

    localparam int unsigned NR = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned W  = DATA_WIDTH;
`ifdef OPERAND_ISSUE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          arst_n;
    logic          in_valid;
    logic          in_ready;
    func_t         in_func;
    logic [AW-1:0] in_rs1, in_rs2, in_rd;
    logic [5:0]    in_imm;
    logic          out_valid;
    logic          out_ready;
    func_t         func_q;
    logic [W-1:0]  rs1_data, rs2_data;
    logic [5:0]    imm_q;
    logic [AW-1:0] rd_addr;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [W-1:0]  wb_data;
    logic [NR-1:0] pending;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0]  m_regs [NR];
    bit            m_pend [NR];
    bit            m_valid;
    func_t         m_func;
    logic [W-1:0]  m_rs1, m_rs2;
    logic [5:0]    m_imm;
    logic [AW-1:0] m_rd;

    always #5 clk = ~clk;

    operand_issue dut (
        .clk_i(clk), .arst_ni(arst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_func_i(in_func),
        .in_rs1_addr_i(in_rs1), .in_rs2_addr_i(in_rs2), .in_rd_addr_i(in_rd), .in_imm_i(in_imm),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .func_o(func_q),
        .rs1_data_o(rs1_data), .rs2_data_o(rs2_data), .imm_o(imm_q), .rd_addr_o(rd_addr),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .pending_o(pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < int'(NR); i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_func  = AND;
        m_rs1   = '0;
        m_rs2   = '0;
        m_imm   = '0;
        m_rd    = '0;
    endtask

    function automatic bit m_eff(input int r);
        return m_pend[r] && !(wb_valid && int'(wb_addr) == r);
    endfunction

    function automatic bit m_ready();
        bit uses2 = !(in_func inside {ADDI, SLLI, SLRI, NOT});
        bit hz = m_eff(int'(in_rs1)) || (uses2 && m_eff(int'(in_rs2))) || m_eff(int'(in_rd));
        return (!m_valid || out_ready) && !hz;
    endfunction

    function automatic logic [W-1:0] m_read(input int r);
        if (ZERO_REG && r == 0) return '0;
        if (wb_valid && int'(wb_addr) == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic logic [NR-1:0] m_pend_vec();
        logic [NR-1:0] v;
        for (int i = 0; i < int'(NR); i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic m_update(input bit acc);
        logic [W-1:0] r1 = m_read(int'(in_rs1));
        logic [W-1:0] r2 = m_read(int'(in_rs2));
        if (acc) begin
            m_valid = 1'b1;
            m_func  = in_func;
            m_rs1   = r1;
            m_rs2   = r2;
            m_imm   = in_imm;
            m_rd    = in_rd;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (wb_valid) begin
            m_pend[int'(wb_addr)] = 1'b0;
            if (!(ZERO_REG && wb_addr == '0)) m_regs[int'(wb_addr)] = wb_data;
        end
        if (acc && !(ZERO_REG && in_rd == '0)) m_pend[int'(in_rd)] = 1'b1;
    endtask

    task automatic drive(input logic v, input func_t f, input int rs1, input int rs2, input int rd,
                         input int imm, input logic ordy, input logic wv, input int wa,
                         input logic [W-1:0] wd);
        in_valid  = v;
        in_func   = f;
        in_rs1    = AW'(rs1);
        in_rs2    = AW'(rs2);
        in_rd     = AW'(rd);
        in_imm    = 6'(imm);
        out_ready = ordy;
        wb_valid  = wv;
        wb_addr   = AW'(wa);
        wb_data   = wd;
    endtask

    // One clock: inputs already driven at negedge; checks ready, then outputs after the edge.
    task automatic step();
        bit acc;
        bit rdy;
        #1;
        rdy = m_ready();
        check("in_ready", 32'(in_ready), 32'(rdy));
        acc = in_valid && rdy;
        @(posedge clk);
        m_update(acc);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("func", 32'(func_q), 32'(m_func));
        check("rs1_data", rs1_data, m_rs1);
        check("rs2_data", rs2_data, m_rs2);
        check("imm", 32'(imm_q), 32'(m_imm));
        check("rd_addr", 32'(rd_addr), 32'(m_rd));
        check("pending", 32'(pending), 32'(m_pend_vec()));
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        int pick;
        in_valid  = ($urandom_range(0, 9) < 7);
        in_func   = func_t'($urandom_range(0, 10));
        in_rs1    = AW'($urandom_range(0, NR - 1));
        in_rs2    = AW'($urandom_range(0, NR - 1));
        in_rd     = AW'($urandom_range(0, NR - 1));
        in_imm    = 6'($urandom);
        out_ready = ($urandom_range(0, 9) < 7);
        wb_valid  = ($urandom_range(0, 9) < 5);
        wb_data   = $urandom;
        pick      = $urandom_range(0, NR - 1);
        // Bias writebacks toward outstanding registers so the scoreboard keeps draining.
        for (int k = 0; k < int'(NR); k++) begin
            if (m_pend[(pick + k) % NR] && $urandom_range(0, 3) != 0) begin
                pick = (pick + k) % NR;
                break;
            end
        end
        wb_addr = AW'(pick);
    endtask

    initial begin
        m_reset();
        arst_n = 1'b0;
        drive(0, AND, 0, 0, 0, 0, 1, 0, 0, '0);
        #23;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_func", 32'(func_q), 32'(AND));
        check("rst_rs1", rs1_data, 32'h0);
        check("rst_pending", 32'(pending), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        // Basic issue
        drive(0, AND, 0, 0, 0, 0, 1, 1, 1, 32'hA5A5A5A5); step();
        drive(0, AND, 0, 0, 0, 0, 1, 1, 2, 32'h5A5A5A5A); step();
        drive(1, AND, 1, 2, 3, 0, 1, 0, 0, '0); step();
        check("basic_valid", 32'(out_valid), 32'(1));
        check("basic_rs1", rs1_data, 32'hA5A5A5A5);
        check("basic_rs2", rs2_data, 32'h5A5A5A5A);
        check("basic_rd", 32'(rd_addr), 32'(3));
        check("basic_pend3", 32'(pending[3]), 32'(1));

        // RAW stall released by writeback with bypass
        drive(1, ADDI, 1, 0, 4, 3, 1, 0, 0, '0); step();
        drive(1, ADD, 4, 1, 4, 0, 1, 0, 0, '0);
        for (int i = 0; i < 2; i++) begin
            #1 check("raw_stall", 32'(in_ready), 32'(0));
            step();
        end
        drive(1, ADD, 4, 1, 4, 0, 1, 1, 4, 32'h00000004);
        #1 check("raw_release", 32'(in_ready), 32'(1));
        step();
        check("raw_bypass", rs1_data, 32'h00000004);
        check("raw_pend4", 32'(pending[4]), 32'(1));

        // Backpressure holds the slot and blocks the next op
        drive(1, XOR, 1, 2, 7, 5, 1, 0, 0, '0); step();
        drive(1, SUB, 2, 1, 8, 9, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_ready", 32'(in_ready), 32'(0));
            step();
            check("bp_hold_rs1", rs1_data, 32'hA5A5A5A5);
            check("bp_hold_rd", 32'(rd_addr), 32'(7));
            check("bp_hold_imm", 32'(imm_q), 32'(5));
        end
        drive(1, SUB, 2, 1, 8, 9, 1, 0, 0, '0); step();
        check("bp_next_func", 32'(func_q), 32'(SUB));
        check("bp_next_rd", 32'(rd_addr), 32'(8));
        check("bp_next_rs1", rs1_data, 32'h5A5A5A5A);

        // Immediate ops ignore the rs2 field
        drive(1, ADD, 1, 1, 5, 0, 1, 0, 0, '0); step();
        drive(1, SLL, 1, 5, 10, 2, 1, 0, 0, '0);
        #1 check("reg_rs2_stall", 32'(in_ready), 32'(0));
        step();
        drive(1, SLLI, 1, 5, 9, 2, 1, 0, 0, '0);
        #1 check("imm_no_stall", 32'(in_ready), 32'(1));
        step();
        check("imm_func", 32'(func_q), 32'(SLLI));
        check("imm_val", 32'(imm_q), 32'(2));

        // Register zero
        drive(0, AND, 0, 0, 0, 0, 1, 1, 0, 32'hFFFFFFFF); step();
        drive(1, OR, 0, 0, 11, 0, 1, 0, 0, '0); step();
        check("r0_rs1", rs1_data, ZERO_REG ? 32'h0 : 32'hFFFFFFFF);
        check("r0_rs2", rs2_data, ZERO_REG ? 32'h0 : 32'hFFFFFFFF);

        // Random traffic with a reset in the middle
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                rand_inputs();
                arst_n = 1'b0;
                #100;
                check("mid_rst_valid", 32'(out_valid), 32'(0));
                check("mid_rst_pending", 32'(pending), 32'(0));
                check("mid_rst_ready", 32'(in_ready), 32'(1));
                m_reset();
                @(negedge clk);
                arst_n = 1'b1;
                for (int r = 1; r < int'(NR); r++) begin
                    drive(1, OR, r, r, r, 0, 1, 0, 0, '0);
                    step();
                    check("post_rst_read", rs1_data, 32'h0);
                end
            end
            rand_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
